// File: rtl/cosmic_trigger_ctrl_if.sv
// Discriminator-side and DAQ-side signals of the cosmic trigger sequencer.
// master = trigger controller, slave = hit source / DAQ readout.
interface cosmic_trigger_ctrl_if #(
    parameter int N_CH = 18
);
    logic [N_CH-1:0] hit;
    logic [N_CH-1:0] ch_mask;
    logic            enable;
    logic [15:0]     prescale;
    logic            daq_ack;
    logic            trig_out;
    logic [N_CH-1:0] hit_pattern;
    logic            pattern_valid;
    logic            busy;
    logic            timeout_err;
    logic [31:0]     trig_count;
    logic [31:0]     cand_count;

    modport master (
        input  hit, ch_mask, enable, prescale, daq_ack,
        output trig_out, hit_pattern, pattern_valid, busy, timeout_err,
               trig_count, cand_count
    );

    modport slave (
        output hit, ch_mask, enable, prescale, daq_ack,
        input  trig_out, hit_pattern, pattern_valid, busy, timeout_err,
               trig_count, cand_count
    );
endinterface

// File: rtl/cosmic_trigger_ctrl.sv
// Cosmic OR trigger sequencer: edge-detect masked hits, gate, prescale, fire, hold pattern for DAQ, dead time.
// Moore outputs; trig_out follows the opening edge by GATE_LEN+1 cycles; DAQ backpressure via daq_ack with timeout.
module cosmic_trigger_ctrl #(
    parameter int N_CH        = 18,
    parameter int GATE_LEN    = 4,
    parameter int DEAD_LEN    = 16,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    cosmic_trigger_ctrl_if.master bus
);
    localparam int CNT_MAX = (ACK_TIMEOUT > DEAD_LEN)
                           ? ((ACK_TIMEOUT > GATE_LEN) ? ACK_TIMEOUT : GATE_LEN)
                           : ((DEAD_LEN > GATE_LEN) ? DEAD_LEN : GATE_LEN);
    localparam int CW = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATE,
        S_FIRE,
        S_WAIT_ACK,
        S_DEAD
    } state_t;

    state_t          state_q, state_d;
    logic [N_CH-1:0] hit_q;
    logic [N_CH-1:0] pat_q, pat_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     ps_cnt_q, ps_cnt_d;
    logic            err_q, err_d;
    logic [31:0]     trig_cnt_q, trig_cnt_d;
    logic [31:0]     cand_cnt_q, cand_cnt_d;
    logic [N_CH-1:0] hit_edge;

    assign hit_edge = bus.hit & ~hit_q & bus.ch_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hit_q      <= '0;
            pat_q      <= '0;
            cnt_q      <= '0;
            ps_cnt_q   <= '0;
            err_q      <= 1'b0;
            trig_cnt_q <= '0;
            cand_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hit_q      <= bus.hit;
            pat_q      <= pat_d;
            cnt_q      <= cnt_d;
            ps_cnt_q   <= ps_cnt_d;
            err_q      <= err_d;
            trig_cnt_q <= trig_cnt_d;
            cand_cnt_q <= cand_cnt_d;
        end
    end

    // One shared counter serves the gate, ack-timeout and dead phases since they never overlap.
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        cnt_d      = cnt_q;
        ps_cnt_d   = ps_cnt_q;
        err_d      = err_q;
        trig_cnt_d = trig_cnt_q;
        cand_cnt_d = cand_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.enable && (|hit_edge)) begin
                    state_d    = S_GATE;
                    pat_d      = hit_edge;
                    cnt_d      = CW'(GATE_LEN - 1);
                    cand_cnt_d = cand_cnt_q + 32'd1;
                end
            end
            S_GATE: begin
                pat_d = pat_q | hit_edge;
                if (cnt_q == '0) begin
                    // >= rather than == so a prescale lowered mid-run accepts immediately.
                    if (ps_cnt_q >= bus.prescale) begin
                        state_d    = S_FIRE;
                        ps_cnt_d   = '0;
                        trig_cnt_d = trig_cnt_q + 32'd1;
                    end else begin
                        state_d  = S_DEAD;
                        ps_cnt_d = ps_cnt_q + 16'd1;
                        pat_d    = '0;
                        cnt_d    = CW'(DEAD_LEN - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIRE: begin
                state_d = S_WAIT_ACK;
                cnt_d   = '0;
            end
            S_WAIT_ACK: begin
                if (bus.daq_ack || (cnt_q == CW'(ACK_TIMEOUT - 1))) begin
                    state_d = S_DEAD;
                    pat_d   = '0;
                    cnt_d   = CW'(DEAD_LEN - 1);
                    if (!bus.daq_ack) err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DEAD: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.trig_out      = (state_q == S_FIRE);
    assign bus.pattern_valid = (state_q == S_FIRE) || (state_q == S_WAIT_ACK);
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.hit_pattern   = pat_q;
    assign bus.timeout_err   = err_q;
    assign bus.trig_count    = trig_cnt_q;
    assign bus.cand_count    = cand_cnt_q;
endmodule

// File: tb/tb_cosmic_trigger_ctrl.sv
// Directed bench for the cosmic trigger sequencer: latency, pattern accumulation, prescale, timeout, mask, reset.
module tb_cosmic_trigger_ctrl;
    localparam int N_CH = 18;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic seen;

    cosmic_trigger_ctrl_if #(.N_CH(N_CH)) bus ();

    cosmic_trigger_ctrl #(
        .N_CH(N_CH), .GATE_LEN(4), .DEAD_LEN(16), .ACK_TIMEOUT(256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".trig"},  32'(bus.trig_out), 32'd0);
        chk({tag, ".valid"}, 32'(bus.pattern_valid), 32'd0);
        chk({tag, ".busy"},  32'(bus.busy), 32'd0);
        chk({tag, ".pat"},   32'(bus.hit_pattern), 32'd0);
        chk({tag, ".err"},   32'(bus.timeout_err), 32'd0);
        chk({tag, ".tcnt"},  bus.trig_count, 32'd0);
        chk({tag, ".ccnt"},  bus.cand_count, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.hit      = '0;
        bus.ch_mask  = '1;
        bus.enable   = 1'b1;
        bus.prescale = 16'd0;
        bus.daq_ack  = 1'b0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // 1: single hit, latency and dead time
        bus.hit = 18'h00008;
        tick();
        chk("t1.busy_k1", 32'(bus.busy), 32'd1);
        repeat (3) tick();
        chk("t1.trig_early", 32'(bus.trig_out), 32'd0);
        tick();
        chk("t1.trig",  32'(bus.trig_out), 32'd1);
        chk("t1.pat",   32'(bus.hit_pattern), 32'h00008);
        chk("t1.valid", 32'(bus.pattern_valid), 32'd1);
        chk("t1.tcnt",  bus.trig_count, 32'd1);
        chk("t1.ccnt",  bus.cand_count, 32'd1);
        tick();
        chk("t1.trig_1cyc", 32'(bus.trig_out), 32'd0);
        chk("t1.valid_wait", 32'(bus.pattern_valid), 32'd1);
        bus.daq_ack = 1'b1;
        tick();
        bus.daq_ack = 1'b0;
        chk("t1.valid_dead", 32'(bus.pattern_valid), 32'd0);
        chk("t1.pat_dead", 32'(bus.hit_pattern), 32'd0);
        repeat (15) tick();
        chk("t1.dead_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("t1.idle", 32'(bus.busy), 32'd0);
        repeat (5) tick();
        chk("t1.level_no_retrig", 32'(bus.busy), 32'd0);
        chk("t1.level_ccnt", bus.cand_count, 32'd1);
        bus.hit = '0;
        tick();

        // 2: pattern accumulation through the last gate edge, ack ignored in FIRE
        bus.hit = 18'h00001;
        tick();
        repeat (3) tick();
        bus.hit = 18'h20001;
        tick();
        chk("t2.trig", 32'(bus.trig_out), 32'd1);
        chk("t2.pat_fire", 32'(bus.hit_pattern), 32'h20001);
        bus.hit = 18'h20021;
        bus.daq_ack = 1'b1;
        tick();
        chk("t2.ack_in_fire_ignored", 32'(bus.pattern_valid), 32'd1);
        chk("t2.pat_wait", 32'(bus.hit_pattern), 32'h20001);
        bus.daq_ack = 1'b0;
        tick();
        bus.daq_ack = 1'b1;
        tick();
        bus.daq_ack = 1'b0;
        chk("t2.valid_after_ack", 32'(bus.pattern_valid), 32'd0);
        repeat (15) tick();
        chk("t2.dead_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("t2.idle", 32'(bus.busy), 32'd0);
        chk("t2.tcnt", bus.trig_count, 32'd2);
        chk("t2.ccnt", bus.cand_count, 32'd2);
        bus.hit = '0;
        tick();

        // 3: prescale 2 over six isolated candidates
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        bus.prescale = 16'd2;
        bus.daq_ack  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.hit = 18'h00002;
            tick();
            seen = 1'b0;
            bus.hit = '0;
            for (int i = 0; i < 39; i++) begin
                tick();
                seen = seen | bus.trig_out;
            end
            chk($sformatf("t3.trig_cand%0d", c + 1), 32'(seen), ((c == 2) || (c == 5)) ? 32'd1 : 32'd0);
        end
        chk("t3.ccnt", bus.cand_count, 32'd6);
        chk("t3.tcnt", bus.trig_count, 32'd2);
        bus.daq_ack = 1'b0;

        // 4a: ack arriving on the final timeout cycle wins
        bus.prescale = 16'd0;
        bus.hit = 18'h00200;
        tick();
        bus.hit = '0;
        repeat (4) tick();
        chk("t4a.trig", 32'(bus.trig_out), 32'd1);
        tick();
        repeat (255) tick();
        chk("t4a.valid_last", 32'(bus.pattern_valid), 32'd1);
        bus.daq_ack = 1'b1;
        tick();
        bus.daq_ack = 1'b0;
        chk("t4a.valid_off", 32'(bus.pattern_valid), 32'd0);
        chk("t4a.no_err", 32'(bus.timeout_err), 32'd0);
        repeat (16) tick();
        chk("t4a.idle", 32'(bus.busy), 32'd0);

        // 4: no ack, timeout after 256 WAIT_ACK cycles
        bus.hit = 18'h00200;
        tick();
        bus.hit = '0;
        repeat (4) tick();
        tick();
        repeat (255) tick();
        chk("t4.valid_held", 32'(bus.pattern_valid), 32'd1);
        chk("t4.err_pre", 32'(bus.timeout_err), 32'd0);
        tick();
        chk("t4.valid_off", 32'(bus.pattern_valid), 32'd0);
        chk("t4.err", 32'(bus.timeout_err), 32'd1);
        chk("t4.dead_busy", 32'(bus.busy), 32'd1);
        repeat (16) tick();
        chk("t4.idle", 32'(bus.busy), 32'd0);
        chk("t4.err_sticky", 32'(bus.timeout_err), 32'd1);
        chk("t4.tcnt", bus.trig_count, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("t4.rst");

        // 5: masked channel and disabled start
        bus.ch_mask = 18'h3FF7F;
        for (int i = 0; i < 6; i++) begin
            bus.hit[7] = ~bus.hit[7];
            tick();
        end
        chk("t5.mask_busy", 32'(bus.busy), 32'd0);
        bus.enable = 1'b0;
        bus.hit = 18'h00004;
        repeat (6) tick();
        chk_all_zero("t5.disabled");
        bus.enable = 1'b1;
        bus.hit = 18'h00010;
        tick();
        tick();
        bus.hit = 18'h00090;
        tick();
        tick();
        tick();
        chk("t5.trig", 32'(bus.trig_out), 32'd1);
        chk("t5.pat_masked", 32'(bus.hit_pattern), 32'h00010);
        bus.daq_ack = 1'b1;
        tick();
        tick();
        bus.daq_ack = 1'b0;
        repeat (16) tick();
        chk("t5.idle", 32'(bus.busy), 32'd0);
        bus.hit = '0;
        bus.ch_mask = '1;
        tick();

        // 6: prescale change mid-run, then reset during WAIT_ACK
        bus.prescale = 16'd1;
        bus.hit = 18'h00001;
        tick();
        bus.hit = '0;
        repeat (4) tick();
        chk("t6.discard_trig", 32'(bus.trig_out), 32'd0);
        chk("t6.discard_busy", 32'(bus.busy), 32'd1);
        repeat (16) tick();
        chk("t6.discard_idle", 32'(bus.busy), 32'd0);
        bus.prescale = 16'd0;
        bus.hit = 18'h00001;
        tick();
        bus.hit = '0;
        repeat (4) tick();
        chk("t6.lowered_ps_trig", 32'(bus.trig_out), 32'd1);
        tick();
        tick();
        chk("t6.wait_valid", 32'(bus.pattern_valid), 32'd1);
        bus.prescale = 16'd1;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("t6.async_rst");
        tick();
        rst = 1'b0;
        bus.hit = 18'h00001;
        tick();
        bus.hit = '0;
        repeat (4) tick();
        chk("t6.fresh_discard", 32'(bus.trig_out), 32'd0);
        chk("t6.fresh_ccnt", bus.cand_count, 32'd1);
        repeat (16) tick();
        bus.hit = 18'h00001;
        tick();
        bus.hit = '0;
        repeat (4) tick();
        chk("t6.fresh_accept", 32'(bus.trig_out), 32'd1);
        chk("t6.fresh_tcnt", bus.trig_count, 32'd1);
        chk("t6.fresh_ccnt2", bus.cand_count, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
